// File: rtl/reflet_pipelined_multiplier.sv
// Fully pipelined WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier with valid/ready handshake.
// Each stage consumes BITS_PER_STAGE multiplier bits; the whole pipe advances or holds as one.
module reflet_pipelined_multiplier #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [WIDTH-1:0]       in_1,
    input  logic [WIDTH-1:0]       in_2,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int STAGES = WIDTH / BITS_PER_STAGE;
    localparam int PW     = 2 * WIDTH;

    logic                 v_r   [STAGES];
    logic                 sg_r  [STAGES];
    logic [TAG_WIDTH-1:0] tag_r [STAGES];
    logic [PW-1:0]        mc_r  [STAGES];
    logic [WIDTH-1:0]     mp_r  [STAGES];
    logic [PW-1:0]        acc_r [STAGES];

    logic [PW-1:0]        mc_nx  [STAGES];
    logic [WIDTH-1:0]     mp_nx  [STAGES];
    logic [PW-1:0]        acc_nx [STAGES];

    logic                 stall;
    logic [PW-1:0]        mc_in;

    // Signed mode weights multiplier bit WIDTH-1 negatively, so its partial product is subtracted.
    function automatic void stage_step(
        input  logic [PW-1:0]    mc,
        input  logic [WIDTH-1:0] mp,
        input  logic [PW-1:0]    acc_src,
        input  logic             sg,
        input  int               k,
        output logic [PW-1:0]    mc_o,
        output logic [WIDTH-1:0] mp_o,
        output logic [PW-1:0]    acc_o
    );
        logic [PW-1:0] acc;
        acc = acc_src;
        for (int j = 0; j < BITS_PER_STAGE; j++) begin
            if (mp[j]) begin
                if (sg && (k * BITS_PER_STAGE + j == WIDTH - 1))
                    acc = acc - (mc << j);
                else
                    acc = acc + (mc << j);
            end
        end
        acc_o = acc;
        mc_o  = mc << BITS_PER_STAGE;
        mp_o  = mp >> BITS_PER_STAGE;
    endfunction

    assign stall     = v_r[STAGES-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign mc_in     = in_signed ? {{WIDTH{in_1[WIDTH-1]}}, in_1} : {{WIDTH{1'b0}}, in_1};

    always_comb begin
        stage_step(mc_in, in_2, '0, in_signed, 0, mc_nx[0], mp_nx[0], acc_nx[0]);
        for (int k = 1; k < STAGES; k++) begin
            stage_step(mc_r[k-1], mp_r[k-1], acc_r[k-1], sg_r[k-1], k,
                       mc_nx[k], mp_nx[k], acc_nx[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k]   <= 1'b0;
                sg_r[k]  <= 1'b0;
                tag_r[k] <= '0;
                mc_r[k]  <= '0;
                mp_r[k]  <= '0;
                acc_r[k] <= '0;
            end
        end else if (!stall) begin
            v_r[0]   <= in_valid;
            sg_r[0]  <= in_signed;
            tag_r[0] <= in_tag;
            for (int k = 1; k < STAGES; k++) begin
                v_r[k]   <= v_r[k-1];
                sg_r[k]  <= sg_r[k-1];
                tag_r[k] <= tag_r[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                mc_r[k]  <= mc_nx[k];
                mp_r[k]  <= mp_nx[k];
                acc_r[k] <= acc_nx[k];
            end
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign out       = acc_r[STAGES-1];
    assign out_tag   = tag_r[STAGES-1];

endmodule

// File: doc/reflet_pipelined_multiplier.md
Name: reflet_pipelined_multiplier

Overview:
- Parametrised, fully pipelined WIDTH x WIDTH -> 2*WIDTH multiplier for the reflet GPU datapath.
- Processes BITS_PER_STAGE multiplier bits per stage, supports signed and unsigned operands per operation, and carries a sideband tag.
- Uses a valid/ready handshake with back-pressure, so one operation can be accepted per cycle.
- Sits between the shader ALU issue logic and the writeback arbiter.

Parameters:
- WIDTH, 16: operand width in bits; must be >= 2.
- BITS_PER_STAGE, 1: multiplier bits consumed per pipeline stage; must divide WIDTH. STAGES = WIDTH/BITS_PER_STAGE.
- TAG_WIDTH, 4: width of the sideband tag carried alongside each operation; must be >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept an operation this cycle.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_1  in  WIDTH  multiplicand.
- in_2  in  WIDTH  multiplier.
- in_tag  in  TAG_WIDTH  sideband tag, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out  out  2*WIDTH  product.
- out_tag  out  TAG_WIDTH  tag of the operation on out.

Behaviour:
- Reset: when reset=0 at a rising edge, every stage valid bit, data register and tag register clears to 0. After that edge: out_valid=0, out=0, out_tag=0, in_ready=1. Reset mid-operation discards all in-flight operations without producing any output.
- Stall:
  - stall = out_valid & ~out_ready; in_ready = ~stall (purely combinational).
  - During a stall, no pipeline register changes.
  - Bubbles are not collapsed: the whole pipeline advances or holds as one.
- Accept: an operation is accepted when in_valid & in_ready. Stage 0 captures its valid bit. When in_valid=0 and not stalled, a bubble (valid=0) enters stage 0.
- Latency:
  - A result appears on out/out_valid exactly STAGES cycles after acceptance, when there are no stalls. Each stall cycle adds one cycle.
  - Throughput is one operation per cycle.
- Per-stage state: valid bit, signed flag, tag, multiplicand, remaining multiplier bits, and a 2*WIDTH accumulator.
- Multiplicand handling:
  - In signed mode the multiplicand is sign-extended to 2*WIDTH; in unsigned mode it is zero-extended.
  - The multiplicand shifts left by BITS_PER_STAGE per stage.
  - The multiplier shifts right by BITS_PER_STAGE per stage.
- Stage k adds partial products for multiplier bits k*B .. k*B+B-1, where B = BITS_PER_STAGE. Each partial product is the multiplicand shifted by that bit's offset, gated by the bit.
- Signed mode: the partial product for multiplier bit WIDTH-1 is subtracted rather than added.
- Arithmetic is modulo 2^(2*WIDTH). out equals the exact 2*WIDTH-bit product for both modes; no overflow is possible.
- out, out_tag and out_valid are registered outputs of the last stage. They remain stable while stalled.
- Data registers of bubbles are don't-care internally. When out_valid=0, out and out_tag are not checked by the bench.
- Simultaneous accept and output: when out_valid & out_ready & in_valid, the pipeline advances and accepts in the same cycle. There is no lost or duplicated operation.
- in_signed is sampled per operation. Mixed signed and unsigned operations may be interleaved back-to-back.

Test Plan:
- Reset and idle (WIDTH=16, B=1): hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out=0, in_ready=1. Release reset with in_valid=0 -> out_valid stays 0.
- Unsigned latency: 0xFFFF*0xFFFF, tag=3, accepted at cycle 0 -> out=0xFFFE0001, out_tag=3, out_valid=1 at cycle 16 only.
- Signed mode: (-3)*5 -> 0xFFFFFFF1. 0x8000*0x8000 signed -> 0x40000000. The same 0x8000*0x8000 unsigned, issued the next cycle -> 0x40000000. 0xFFFF*0x0002 signed -> 0xFFFFFFFE vs unsigned -> 0x0001FFFE.
- Back-pressure: stream 20 random ops back-to-back with out_ready toggling pseudo-randomly -> results in issue order, each matching the reference product and tag exactly once. in_ready=0 exactly during stall cycles; out held stable while stalled.
- Reset mid-flight: accept 8 ops, then reset=0 for 1 cycle -> none of those 8 results ever appears. The first op after release emerges with latency 16.
- Parameter sweep: WIDTH=8, B=4 (STAGES=2) -> 0xFF*0xFF unsigned = 0xFE01 after 2 cycles; 0x80*0x7F signed = 0xC080.
